// File: rtl/line_window_buffer.sv
// line_window_buffer: raster-scan ROWSxROWS window generator built on circular line memories.
// Optional LWB_VALID_MASK_EN forces oGrid to zero while oValid is low.
module line_window_buffer #(
    parameter int DATA_W   = 30,
    parameter int LINE_LEN = 640,
    parameter int ROWS     = 3
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          clken,
    input  logic                          sof,
    input  logic [DATA_W-1:0]             shiftin,
    output logic [DATA_W*ROWS*ROWS-1:0]   oGrid,
    output logic                          oValid
);
    localparam int XW = $clog2(LINE_LEN);
    localparam int YW = $clog2(ROWS);
    localparam logic [XW-1:0] X_LAST = XW'(LINE_LEN - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(ROWS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    logic [XW-1:0]     r_x, w_x;
    logic [YW-1:0]     r_y, w_y;
    logic              r_first, r_valid, w_restart;
    logic [DATA_W-1:0] r_mem [ROWS-1][LINE_LEN];
    logic [DATA_W-1:0] r_win [ROWS*ROWS];
    logic [DATA_W-1:0] w_col [ROWS];

    // r_first makes the first accept after reset land on (0,0) without needing sof
    always_comb begin
        w_restart = sof || r_first;
        w_x = (w_restart || r_x == X_LAST) ? '0 : r_x + 1'b1;
        w_y = w_restart ? '0 : (r_x == X_LAST && r_y != Y_LAST) ? r_y + 1'b1 : r_y;
    end

    assign w_col[0] = shiftin;
    for (genvar r = 1; r < ROWS; r++) begin : g_col
        assign w_col[r] = r_mem[r-1][w_x];
    end

    // Line memories carry no reset; stale lines are hidden by oValid
    always_ff @(posedge clock) begin
        if (clken) begin
            r_mem[0][w_x] <= shiftin;
            for (int k = 1; k < ROWS - 1; k++)
                r_mem[k][w_x] <= r_mem[k-1][w_x];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_first <= 1'b1;
            r_valid <= 1'b0;
            for (int k = 0; k < ROWS * ROWS; k++)
                r_win[k] <= '0;
        end else if (clken) begin
            r_x     <= w_x;
            r_y     <= w_y;
            r_first <= 1'b0;
            r_valid <= (w_y == Y_LAST) && (w_x >= X_MIN);
            for (int r = 0; r < ROWS; r++) begin
                r_win[r*ROWS] <= w_col[r];
                for (int c = 1; c < ROWS; c++)
                    r_win[r*ROWS+c] <= r_win[r*ROWS+c-1];
            end
        end
    end

    for (genvar k = 0; k < ROWS * ROWS; k++) begin : g_out
`ifdef LWB_VALID_MASK_EN
        assign oGrid[DATA_W*k +: DATA_W] = r_valid ? r_win[k] : '0;
`else
        assign oGrid[DATA_W*k +: DATA_W] = r_win[k];
`endif
    end

    assign oValid = r_valid;
endmodule

// File: tb/tb_line_window_buffer.sv
// tb_line_window_buffer: directed plus randomized checks against a frame-coordinate reference model.
module tb_line_window_buffer;
    localparam int DW = 8, LL = 8, RW = 3, GW = DW * RW * RW;

    logic          clock = 1'b0, reset_n = 1'b0, clken = 1'b0, sof = 1'b0;
    logic [DW-1:0] shiftin = '0;
    logic [GW-1:0] oGrid;
    logic          oValid;

    int total = 0, bad = 0;
    int mx, mty;
    bit mfirst, evalid;
    logic [DW-1:0] img [RW][LL];
    logic [DW-1:0] hist [$];

    always #5 clock = ~clock;

    line_window_buffer #(.DATA_W(DW), .LINE_LEN(LL), .ROWS(RW)) dut (
        .clock(clock), .reset_n(reset_n), .clken(clken), .sof(sof),
        .shiftin(shiftin), .oGrid(oGrid), .oValid(oValid)
    );

    task automatic chk(input string tag, input logic [GW-1:0] got, input logic [GW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] slot(input int k);
        return oGrid[DW*k +: DW];
    endfunction

    task automatic model_reset();
        mfirst = 1; mx = 0; mty = 0; evalid = 0;
        hist.delete();
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, GW'(oValid), GW'(evalid));
        for (int k = 0; k < RW * RW; k++) begin
            int r, c;
            r = k / RW;
            c = k % RW;
            if (evalid)
                chk($sformatf("%s_s%0d", tag, k), GW'(slot(k)), GW'(img[(mty - r) % RW][mx - c]));
`ifdef LWB_VALID_MASK_EN
            else
                chk($sformatf("%s_mask%0d", tag, k), GW'(slot(k)), '0);
`else
            else if (r == 0)
                chk($sformatf("%s_row0_%0d", tag, k), GW'(slot(k)), GW'(c < hist.size() ? hist[c] : '0));
`endif
        end
    endtask

    // Pixel coordinates follow the frame rules directly; mty is the unsaturated row
    task automatic step(input bit en, input bit s, input logic [DW-1:0] p, input string tag);
        clken = en; sof = s; shiftin = p;
        @(posedge clock);
        #1;
        if (en) begin
            if (mfirst || s) begin mx = 0; mty = 0; end
            else if (mx == LL - 1) begin mx = 0; mty++; end
            else mx++;
            mfirst = 0;
            img[mty % RW][mx] = p;
            hist.push_front(p);
            if (hist.size() > RW) void'(hist.pop_back());
            evalid = (mty >= RW - 1) && (mx >= RW - 1);
        end
        check_all(tag);
        clken = 0; sof = 0;
    endtask

    task automatic pulse_reset();
        clken = 0;
        reset_n = 0;
        #1;
        chk("rst_grid", oGrid, '0);
        chk("rst_valid", GW'(oValid), '0);
        #1 reset_n = 1;
        model_reset();
    endtask

    initial begin
        int acc;
        model_reset();
        @(posedge clock);
        #1;
        pulse_reset();

        for (int i = 0; i < 27; i++) begin
            step(1, 0, DW'((i / LL) * 16 + i % LL), "basic");
            if (i == 18) begin
                chk("basic_v", GW'(oValid), GW'(1));
                chk("basic_s0", GW'(slot(0)), GW'(8'h22));
                chk("basic_s4", GW'(slot(4)), GW'(8'h11));
                chk("basic_s8", GW'(slot(8)), GW'(8'h00));
            end
            if (i == 24 || i == 25) chk("wrap_v0", GW'(oValid), '0);
            if (i == 26) begin
                chk("wrap_v1", GW'(oValid), GW'(1));
                chk("wrap_s0", GW'(slot(0)), GW'(8'h32));
                chk("wrap_s8", GW'(slot(8)), GW'(8'h10));
            end
        end

        // Row 3 in progress: asynchronous reset, then restart at (0,0)
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1, 0, DW'(8'h55 + i), "post_rst");

        pulse_reset();
        acc = 0;
        for (int cyc = 0; acc < 19; cyc++) begin
            bit en;
            en = (cyc % 4 == 0) || (cyc % 4 == 3);
            step(en, en ? 1'b0 : 1'(cyc % 2), en ? DW'((acc / LL) * 16 + acc % LL) : DW'($urandom), "gap");
            if (en) acc++;
        end
        chk("gap_s0", GW'(slot(0)), GW'(8'h22));
        chk("gap_s8", GW'(slot(8)), GW'(8'h00));

        pulse_reset();
        for (int i = 0; i < 21; i++) step(1, 0, DW'((i / LL) * 16 + i % LL), "pre_sof");
        for (int i = 0; i < 19; i++) begin
            step(1, i == 0, DW'(8'h80 + (i / LL) * 16 + i % LL), "sof");
            if (i < 18) chk("sof_v0", GW'(oValid), '0);
        end
        chk("sof_v1", GW'(oValid), GW'(1));
        chk("sof_s8", GW'(slot(8)), GW'(8'h80));

        // sof at the last column must win over the line wrap
        pulse_reset();
        for (int i = 0; i < LL - 1; i++) step(1, 0, DW'(i), "pre_edge");
        step(1, 1, DW'(8'hE0), "edge_sof");
        for (int i = 1; i < 2 * LL + 3; i++) step(1, 0, DW'(8'hE0 + i), "edge_after");

        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 500) == 0) pulse_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 70) == 0, DW'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/line_window_buffer.md
# line_window_buffer

Parametrised raster-scan window generator for the edge-detection pipeline. It accepts one pixel per enabled clock, stores `ROWS-1` previous lines in circular line memories, and presents a registered `ROWS`×`ROWS` neighbourhood together with a validity flag and frame-position tracking. It sits between the pixel source (camera/VGA capture) and the Sobel/Canny kernel stages. It replaces fixed 3-line shift-register buffers with an address-counter design.

## Interface
- `DATA_W`, 30: bits per pixel sample.
- `LINE_LEN`, 640: pixels per line; legal range `ROWS`..4096.
- `ROWS`, 3: window height and width; odd, legal range 3..7. `R` = (`ROWS`-1)/2.

- `clock`  in  1  rising-edge system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `clken`  in  1  sample accept; all state advances only when high.
- `sof`  in  1  start of frame; qualified by `clken`, marks `shiftin` as pixel (0,0).
- `shiftin`  in  `DATA_W`  incoming pixel, raster order.
- `oGrid`  out  `DATA_W*ROWS*ROWS`  window taps; slot k = `oGrid[DATA_W*k +: DATA_W]`.
- `oValid`  out  1  window lies fully inside the frame.

## Operation
- Counters:
  - column counter `x` runs 0..`LINE_LEN`-1;
  - row counter `y` saturates at `ROWS`-1.
  - Both describe the sample accepted on the current edge.
- Per accepted sample, the counters update as follows:
  - `sof`=1: `x`=0, `y`=0.
  - Else if the previous `x`=`LINE_LEN`-1: `x`=0 and `y` increments (saturating).
  - Else `x` increments.
  - The first accepted sample after reset is (0,0) whether or not `sof` is asserted.
- Line memories:
  - There are `ROWS`-1 memories, M0..M(`ROWS`-2), each `LINE_LEN` deep, addressed by `x`.
  - On accept, each memory is read at `x` with read-before-write semantics.
  - Writes: M0[x] <= `shiftin`; Mk[x] <= old M(k-1)[x].
  - The column vector is {`shiftin`, M0[x], …, M(`ROWS`-2)[x]}: the newest row first, holding pixels (y,x), (y-1,x), …
- Window:
  - The window is a `ROWS`×`ROWS` register array. On accept, every column shifts one place older and the new column vector loads column 0.
  - Slot k = r·`ROWS`+c, where r=0 is the newest row (bottom) and c=0 is the newest column (right).
  - After accepting (y,x), slot (r,c) holds pixel (y-r, x-c). Slot `ROWS`²-1 is top-left, and slot R·`ROWS`+R is the centre pixel (y-R, x-R).
- `oValid` is registered on accept as (`y` = `ROWS`-1 saturated) AND (`x` ≥ `ROWS`-1).
  - It is 0 whenever the window straddles a line wrap, sits above the first full row, or follows `sof` by fewer than `ROWS`-1 lines.
- Line memories are never cleared. Reset and `sof` rely on `oValid` gating to hide stale contents.
- When `clken` is low, the counters, memories, window and `oValid` hold.

## Timing
- Output latency is 1 edge: the sample accepted at edge n appears in slot 0 after edge n.
- The centre pixel lags the input by R·`LINE_LEN`+R accepted samples.
- Reset values: all window registers 0, `oGrid`=0, `oValid`=0, `x`=0, `y`=0.
  - Reset asserted mid-frame clears these immediately (asynchronously).
  - Memory contents are undefined after reset.
- `sof` coincident with an accept at `x`=`LINE_LEN`-1 takes priority over wrap: the result is (0,0) with no row increment.
- `sof` without `clken` is ignored.
- Throughput is one sample per clock, with no back-pressure.

## Configuration
- `LWB_VALID_MASK_EN`:
  - Defined: `oGrid` drives all-zero whenever `oValid`=0, so downstream kernels see zero taps outside the valid region.
  - Undefined: `oGrid` always drives the raw window registers, including stale or straddling data.
  - In both builds, `oValid` timing and memory behaviour are identical.

## Test plan
- Basic window: `DATA_W`=8, `LINE_LEN`=8, `ROWS`=3; reset, then stream pixel value y·16+x with `clken` high.
  - After the 19th accept (pixel 0x22): `oValid`=1, slot0=0x22, slot4=0x11, slot8=0x00.
- Line wrap: same stream through accepts of (3,0) and (3,1) -> `oValid`=0 on both; accept (3,2) -> `oValid`=1, slot0=0x32, slot8=0x10.
- Enable gaps: repeat the basic window test with `clken` toggling 1,0,0,1 -> identical `oGrid`/`oValid` sequence per accept, and outputs held during low cycles.
- Mid-line frame restart: assert `sof` on the sample at (2,5), then continue streaming.
  - `oValid` stays 0 until (2,2) of the new frame, after which taps contain only new-frame values.
- Reset mid-frame: pulse `reset_n` low between clocks during row 3.
  - `oGrid`=0 and `oValid`=0 immediately; the next accept is treated as (0,0).
- Masking: build with `LWB_VALID_MASK_EN`; during row 0, `oGrid`=0. Without the macro, slot0 equals the last accepted pixel during row 0.
